counter_bank: RTL and testbench

//  Bank of NUM_CH independent, parametrised up/down counters sharing one clock and one prescaler.

---
 rtl/counter_bank_if.sv | 27 ++
 rtl/counter_bank.sv | 123 ++++++++++++
 tb/tb_counter_bank.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/counter_bank_if.sv
// Signal bundle between a counter_bank and its user: per-channel controls in,
// count/status out. Multi-bit fields pack channel i at [i*WIDTH +: WIDTH].
interface counter_bank_if #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 16
);
    logic [NUM_CH-1:0]       en;
    logic [NUM_CH-1:0]       dir;
    logic [NUM_CH-1:0]       load;
    logic [NUM_CH*WIDTH-1:0] load_val;
    logic [NUM_CH-1:0]       clear;
    logic [NUM_CH*WIDTH-1:0] cmp_val;
    logic [NUM_CH*WIDTH-1:0] count;
    logic [NUM_CH-1:0]       tc_pulse;
    logic [NUM_CH-1:0]       match;
    logic [NUM_CH-1:0]       done;

    modport master (
        output en, dir, load, load_val, clear, cmp_val,
        input  count, tc_pulse, match, done
    );

    modport slave (
        input  en, dir, load, load_val, clear, cmp_val,
        output count, tc_pulse, match, done
    );
endinterface

// File: rtl/counter_bank.sv
// Bank of NUM_CH independent up/down counters sharing one prescaler, with
// wrap/saturate/one-shot terminal behaviour, terminal-count pulses and compare flags.
module counter_bank #(
    parameter int NUM_CH   = 4,
    parameter int WIDTH    = 16,
    parameter int MODE     = 0,
    parameter int PRESCALE = 1
) (
    input  logic            clk,
    input  logic            reset,
    counter_bank_if.slave   bus
);
    localparam int              PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

    logic [PW-1:0]           r_presc;
    logic                    w_tick;
    logic [NUM_CH*WIDTH-1:0] r_count;
    logic [NUM_CH-1:0]       r_tc;
    logic [NUM_CH-1:0]       r_done;
    logic [NUM_CH*WIDTH-1:0] w_count_nxt;
    logic [NUM_CH-1:0]       w_tc_nxt;
    logic [NUM_CH-1:0]       w_done_nxt;
    logic [NUM_CH-1:0]       w_match;

    // Next state of one channel, returned as {tc, done, count}.
    function automatic logic [WIDTH+1:0] f_channel_next(
        input logic [WIDTH-1:0] cur,
        input logic             done_cur,
        input logic             clr,
        input logic             ld,
        input logic [WIDTH-1:0] ld_val,
        input logic             step,
        input logic             up
    );
        logic [WIDTH-1:0] nxt;
        logic [WIDTH-1:0] term;
        logic             tc;
        logic             dn;
        term = up ? CNT_MAX : {WIDTH{1'b0}};
        nxt  = cur;
        tc   = 1'b0;
        dn   = done_cur;
        if (clr) begin
            nxt = {WIDTH{1'b0}};
            dn  = 1'b0;
        end else if (ld) begin
            nxt = ld_val;
            dn  = 1'b0;
        end else if (step) begin
            if (cur == term) begin
                // Leaving the terminal value never pulses; saturate pins it.
                case (MODE)
                    1:       nxt = cur;
                    default: nxt = up ? {WIDTH{1'b0}} : CNT_MAX;
                endcase
            end else begin
                nxt = up ? (cur + WIDTH'(1)) : (cur - WIDTH'(1));
                if (nxt == term) begin
                    tc = 1'b1;
                    dn = (MODE == 2) ? 1'b1 : done_cur;
                end else begin
                    tc = 1'b0;
                end
            end
        end else begin
            nxt = cur;
        end
        return {tc, dn, nxt};
    endfunction

    // Prescaler strobe: high in the cycle the prescaler sits at its last value.
    always_comb begin
        w_tick = (r_presc == PRE_LAST);
    end

    // Per-channel next-state evaluation.
    always_comb begin
        w_count_nxt = r_count;
        w_tc_nxt    = '0;
        w_done_nxt  = r_done;
        for (int i = 0; i < NUM_CH; i++) begin
            {w_tc_nxt[i], w_done_nxt[i], w_count_nxt[i*WIDTH +: WIDTH]} = f_channel_next(
                r_count[i*WIDTH +: WIDTH],
                r_done[i],
                bus.clear[i],
                bus.load[i],
                bus.load_val[i*WIDTH +: WIDTH],
                w_tick & bus.en[i] & ~r_done[i],
                bus.dir[i]
            );
        end
    end

    // State registers for the prescaler and all channels.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc <= '0;
            r_count <= '0;
            r_tc    <= '0;
            r_done  <= '0;
        end else begin
            r_presc <= w_tick ? PW'(0) : (r_presc + PW'(1));
            r_count <= w_count_nxt;
            r_tc    <= w_tc_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Compare flags follow the registered count.
    always_comb begin
        w_match = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_match[i] = (r_count[i*WIDTH +: WIDTH] == bus.cmp_val[i*WIDTH +: WIDTH]);
        end
    end

    assign bus.count    = r_count;
    assign bus.tc_pulse = r_tc;
    assign bus.done     = r_done;
    assign bus.match    = w_match;
endmodule

// File: tb/tb_counter_bank.sv
// Directed bench for counter_bank: one instance per mode plus a prescaled
// instance, all with NUM_CH=2, WIDTH=4.
module tb_counter_bank;
    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    counter_bank_if #(.NUM_CH(2), .WIDTH(4)) if0 ();
    counter_bank_if #(.NUM_CH(2), .WIDTH(4)) if1 ();
    counter_bank_if #(.NUM_CH(2), .WIDTH(4)) if2 ();
    counter_bank_if #(.NUM_CH(2), .WIDTH(4)) if3 ();

    counter_bank #(.NUM_CH(2), .WIDTH(4), .MODE(0), .PRESCALE(1)) u_wrap (.clk(clk), .reset(reset), .bus(if0));
    counter_bank #(.NUM_CH(2), .WIDTH(4), .MODE(1), .PRESCALE(1)) u_sat  (.clk(clk), .reset(reset), .bus(if1));
    counter_bank #(.NUM_CH(2), .WIDTH(4), .MODE(2), .PRESCALE(1)) u_os   (.clk(clk), .reset(reset), .bus(if2));
    counter_bank #(.NUM_CH(2), .WIDTH(4), .MODE(0), .PRESCALE(3)) u_pre  (.clk(clk), .reset(reset), .bus(if3));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        {if0.en, if0.dir, if0.load, if0.clear, if0.load_val, if0.cmp_val} = '0;
        {if1.en, if1.dir, if1.load, if1.clear, if1.load_val, if1.cmp_val} = '0;
        {if2.en, if2.dir, if2.load, if2.clear, if2.load_val, if2.cmp_val} = '0;
        {if3.en, if3.dir, if3.load, if3.clear, if3.load_val, if3.cmp_val} = '0;
        step();
        step();
        reset = 1'b0;

        // Reset state
        chk("rst_count0", if0.count, 8'h00);
        chk("rst_tc0", if0.tc_pulse, 2'b00);
        chk("rst_match0", if0.match, 2'b11);
        chk("rst_done2", if2.done, 2'b00);
        chk("rst_count3", if3.count, 8'h00);

        // 1: wrap mode counts up 1..15, pulses at 15, wraps silently to 0
        if0.en = 2'b01;
        if0.dir = 2'b01;
        for (int k = 1; k <= 15; k++) begin
            step();
            chk("wrap_count", if0.count, {4'd0, 4'(k)});
            chk("wrap_tc", if0.tc_pulse, (k == 15) ? 2'b01 : 2'b00);
        end
        step();
        chk("wrap_to0_count", if0.count, 8'h00);
        chk("wrap_to0_tc", if0.tc_pulse, 2'b00);
        if0.en = 2'b00;

        // 2: saturate mode, ch1 down from 2, holds at 0, then turns up
        if1.load = 2'b10;
        if1.load_val = {4'd2, 4'd0};
        step();
        chk("sat_load", if1.count, {4'd2, 4'd0});
        if1.load = 2'b00;
        if1.en = 2'b10;
        if1.dir = 2'b00;
        step();
        chk("sat_1", if1.count, {4'd1, 4'd0});
        chk("sat_1_tc", if1.tc_pulse, 2'b00);
        step();
        chk("sat_0", if1.count, 8'h00);
        chk("sat_0_tc", if1.tc_pulse, 2'b10);
        step();
        chk("sat_hold", if1.count, 8'h00);
        chk("sat_hold_tc", if1.tc_pulse, 2'b00);
        step();
        chk("sat_hold2", if1.count, 8'h00);
        if1.dir = 2'b10;
        step();
        chk("sat_up", if1.count, {4'd1, 4'd0});
        chk("sat_up_tc", if1.tc_pulse, 2'b00);
        if1.en = 2'b00;

        // 3: one-shot from 13 halts at 15, load restarts it
        if2.load = 2'b01;
        if2.load_val = {4'd0, 4'd13};
        step();
        chk("os_load", if2.count, {4'd0, 4'd13});
        if2.load = 2'b00;
        if2.en = 2'b01;
        if2.dir = 2'b01;
        step();
        chk("os_14", if2.count, {4'd0, 4'd14});
        chk("os_14_done", if2.done, 2'b00);
        step();
        chk("os_15", if2.count, {4'd0, 4'd15});
        chk("os_15_tc", if2.tc_pulse, 2'b01);
        chk("os_15_done", if2.done, 2'b01);
        step();
        chk("os_halt", if2.count, {4'd0, 4'd15});
        chk("os_halt_tc", if2.tc_pulse, 2'b00);
        chk("os_halt_done", if2.done, 2'b01);
        if2.load = 2'b01;
        if2.load_val = {4'd0, 4'd3};
        step();
        chk("os_reload", if2.count, {4'd0, 4'd3});
        chk("os_reload_done", if2.done, 2'b00);
        if2.load = 2'b00;
        step();
        chk("os_run", if2.count, {4'd0, 4'd4});
        if2.en = 2'b00;

        // 4: prescale 3 from a fresh reset: 0,0,1,1,1,2,...
        if3.en = 2'b01;
        if3.dir = 2'b01;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("pre_rst", if3.count, 8'h00);
        for (int k = 1; k <= 9; k++) begin
            step();
            chk("pre_count", if3.count, {4'd0, 4'(k / 3)});
        end
        if3.en = 2'b00;

        // 5: clear beats load on ch1; load beats step on ch0; compare match
        if0.clear = 2'b10;
        if0.load = 2'b11;
        if0.load_val = {4'd9, 4'd9};
        if0.en = 2'b01;
        if0.dir = 2'b01;
        if0.cmp_val = {4'd5, 4'd9};
        #1;
        chk("cmp_pre", if0.match, 2'b00);
        step();
        chk("cl_ld_count", if0.count, {4'd0, 4'd9});
        chk("cl_ld_match", if0.match, 2'b01);
        if0.clear = 2'b00;
        if0.load = 2'b00;
        step();
        chk("post_ld_count", if0.count, {4'd0, 4'd10});
        chk("post_ld_match", if0.match, 2'b00);
        if0.en = 2'b00;

        // 6: reset mid-operation drops count, done and a pending pulse
        if2.load = 2'b11;
        if2.load_val = {4'd1, 4'd6};
        step();
        if2.load = 2'b00;
        if2.en = 2'b11;
        if2.dir = 2'b01;
        step();
        chk("mid_count", if2.count, {4'd0, 4'd7});
        chk("mid_done", if2.done, 2'b10);
        chk("mid_tc", if2.tc_pulse, 2'b10);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst2_count", if2.count, 8'h00);
        chk("rst2_done", if2.done, 2'b00);
        chk("rst2_tc", if2.tc_pulse, 2'b00);
        chk("rst2_count0", if0.count, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
